// File: rtl/shake128_absorb_pad_if.sv
// Handshake bundle between the message source, the absorb/pad block and the permutation core.
// The master side feeds chunks and accepts blocks; the slave side is the absorb/pad block.
interface shake128_absorb_pad_if;
    logic [1023:0] din;
    logic [6:0]    byte_len;
    logic          i_valid;
    logic          i_last;
    logic          i_ack;
    logic [1343:0] blk_data;
    logic          blk_valid;
    logic          blk_ready;
    logic          blk_last;
    logic          busy;
    logic          done;

    modport master (
        output din, byte_len, i_valid, i_last, blk_ready,
        input  i_ack, blk_data, blk_valid, blk_last, busy, done
    );

    modport slave (
        input  din, byte_len, i_valid, i_last, blk_ready,
        output i_ack, blk_data, blk_valid, blk_last, busy, done
    );
endinterface

// File: rtl/shake128_absorb_pad.sv
// SHAKE128 absorb front end: packs 128-byte chunks into 168-byte rate blocks and applies
// the 0x1F..0x80 domain/pad bytes to the final block.
module shake128_absorb_pad (
    input  logic                    clk,
    input  logic                    rst,
    shake128_absorb_pad_if.slave    bus
);
    typedef enum logic [2:0] {S_IDLE, S_MERGE, S_EMIT, S_PAD, S_FIN} state_t;

    state_t         r_state;
    logic [1023:0]  r_din;
    logic [7:0]     r_n;
    logic           r_last;
    logic [1343:0]  r_acc;
    logic [7:0]     r_fill;
    logic [1015:0]  r_spill;
    logic           r_ack;
    logic           r_blk_valid;
    logic           r_blk_last;
    logic           r_done;

    logic [8:0]     w_total;
    logic [1023:0]  w_chunk;
    logic [2367:0]  w_wide;
    logic [1343:0]  w_merged;
    logic [1015:0]  w_spill_new;

    function automatic logic [1343:0] f_pad(input logic [1343:0] a, input logic [7:0] pos);
        logic [1343:0] t;
        t = a;
        t[{pos, 3'b000} +: 8] = t[{pos, 3'b000} +: 8] ^ 8'h1F;
        t[1343:1336]          = t[1343:1336] ^ 8'h80;
        return t;
    endfunction

    assign w_total = {1'b0, r_fill} + {1'b0, r_n};

    // Bytes past the chunk length are dropped so the OR-merge below never pollutes acc.
    always_comb begin
        w_chunk = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < int'(r_n))
                w_chunk[8*i +: 8] = r_din[8*i +: 8];
        end
    end

    // acc is zero from byte `fill` upward, so placing the chunk is a shift and an OR;
    // whatever lands above byte 167 is the spill, chunk byte (168-fill) first.
    assign w_wide      = {1344'b0, w_chunk} << {r_fill, 3'b000};
    assign w_merged    = r_acc | w_wide[1343:0];
    assign w_spill_new = w_wide[2359:1344];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_din       <= '0;
            r_n         <= '0;
            r_last      <= 1'b0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_spill     <= '0;
            r_ack       <= 1'b0;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_din   <= bus.din;
                        r_last  <= bus.i_last;
                        r_n     <= bus.i_last ? {1'b0, bus.byte_len} : 8'd128;
                        r_ack   <= 1'b1;
                        r_state <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    r_spill <= w_spill_new;
                    if (w_total < 9'd168) begin
                        if (r_last) begin
                            r_acc       <= f_pad(w_merged, w_total[7:0]);
                            r_blk_last  <= 1'b1;
                            r_blk_valid <= 1'b1;
                            r_state     <= S_EMIT;
                        end else begin
                            r_acc   <= w_merged;
                            r_fill  <= w_total[7:0];
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_acc       <= w_merged;
                        r_fill      <= 8'(w_total - 9'd168);
                        r_blk_last  <= 1'b0;
                        r_blk_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.blk_ready) begin
                        r_blk_valid <= 1'b0;
                        if (r_blk_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_acc   <= {328'b0, r_spill};
                            r_spill <= '0;
                            r_state <= r_last ? S_PAD : S_IDLE;
                        end
                    end
                end
                S_PAD: begin
                    r_acc       <= f_pad(r_acc, r_fill);
                    r_blk_last  <= 1'b1;
                    r_blk_valid <= 1'b1;
                    r_state     <= S_EMIT;
                end
                S_FIN: begin
                    r_acc      <= '0;
                    r_fill     <= '0;
                    r_spill    <= '0;
                    r_blk_last <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.i_ack     = r_ack;
    assign bus.blk_data  = r_acc;
    assign bus.blk_valid = r_blk_valid;
    assign bus.blk_last  = r_blk_last;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != S_IDLE);
endmodule
